timer: RTL

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/timer.sv
// timer: memory-mapped periodic / one-shot timer with prescaler and compare match.
//
// Register map (addr_i[3:2]):
//   0x0 CTRL  : bit0 EN, bit1 IE, bit2 PEND (write-1-to-clear), bit3 ONESHOT
//   0x4 COUNT : 32-bit counter, advances once per prescaler tick
//   0x8 CMP   : 32-bit compare value
//   0xC PSC   : prescaler reload, low PSC_W bits held
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   we_i      : single-cycle bus write strobe
//   addr_i    : bus byte address, only [3:2] decoded
//   data_i    : bus write data
//   data_o    : bus read data, combinational from addr_i[3:2]
//   int_sig_o : registered interrupt request, PEND & IE

module timer #(
    parameter int unsigned PSC_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o
);

    localparam int unsigned DATA_W = 32;
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_COUNT = 2'd1;
    localparam logic [1:0] ADDR_CMP   = 2'd2;
    localparam logic [1:0] ADDR_PSC   = 2'd3;

    logic              r_en;
    logic              r_ie;
    logic              r_pend;
    logic              r_oneshot;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_cmp;
    logic [PSC_W-1:0]  r_psc;
    logic [PSC_W-1:0]  r_psc_cnt;
    logic              r_int_sig;

    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_cmp;
    logic w_wr_psc;
    logic w_tick;
    logic w_match;
    logic w_unused;

    // Address decode for writes
    assign w_wr_ctrl  = we_i && (addr_i[3:2] == ADDR_CTRL);
    assign w_wr_count = we_i && (addr_i[3:2] == ADDR_COUNT);
    assign w_wr_cmp   = we_i && (addr_i[3:2] == ADDR_CMP);
    assign w_wr_psc   = we_i && (addr_i[3:2] == ADDR_PSC);

    // Tick when the prescaler has reached its reload value; match is checked only on a tick
    assign w_tick  = r_en && (r_psc_cnt == r_psc);
    assign w_match = w_tick && (r_count == r_cmp);

    // Control register; a hardware match overrides a concurrent software write for PEND and EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_pend    <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en      <= data_i[0];
                r_ie      <= data_i[1];
                r_oneshot <= data_i[3];
                r_pend    <= r_pend & ~data_i[2];
            end
            if (w_match) begin
                r_pend <= 1'b1;
                if (r_oneshot) begin
                    r_en <= 1'b0;
                end
            end
        end
    end

    // Prescaler: held at zero while disabled, reloads to zero on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
        end else if (!r_en || w_tick) begin
            r_psc_cnt <= '0;
        end else begin
            r_psc_cnt <= r_psc_cnt + PSC_W'(1);
        end
    end

    // Main counter; a software write beats any same-edge tick, and wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= data_i;
        end else if (w_match) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + DATA_W'(1);
        end
    end

    // Compare and prescaler reload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp <= '0;
            r_psc <= '0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= data_i;
            end
            if (w_wr_psc) begin
                r_psc <= data_i[PSC_W-1:0];
            end
        end
    end

    // Interrupt request follows PEND & IE by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_sig <= 1'b0;
        end else begin
            r_int_sig <= r_pend & r_ie;
        end
    end

    assign int_sig_o = r_int_sig;

    // Read mux, side-effect free
    always_comb begin
        data_o = '0;
        case (addr_i[3:2])
            ADDR_CTRL:  data_o = {28'd0, r_oneshot, r_pend, r_ie, r_en};
            ADDR_COUNT: data_o = r_count;
            ADDR_CMP:   data_o = r_cmp;
            ADDR_PSC:   data_o = DATA_W'(r_psc);
            default:    data_o = '0;
        endcase
    end

    // Address bits outside the register decode are intentionally ignored
    assign w_unused = &{1'b0, addr_i[31:4], addr_i[1:0]};

endmodule
